// File: rtl/game_timer.sv
// Game clock: four-state run/pause/over controller with a seconds prescaler,
// saturating seconds counter, incremental BCD digits and a difficulty stage.
module game_timer #(
  parameter int unsigned CLK_HZ = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       game_over,
  output logic [7:0] seconds,
  output logic       sec_tick,
  output logic [3:0] sec_hund,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] stage,
  output logic       stage_up,
  output logic       running
);

  localparam int unsigned    PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(CLK_HZ - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, OVER} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    sec_q, sec_d;
  logic [3:0]    hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
  logic [1:0]    stage_q, stage_d;
  logic          tick_q, tick_d, up_q, up_d, run_q, run_d;
  logic          clear, count_en;

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    sec_d    = sec_q;
    hund_d   = hund_q;
    tens_d   = tens_q;
    ones_d   = ones_q;
    stage_d  = stage_q;
    tick_d   = 1'b0;
    up_d     = 1'b0;
    clear    = 1'b0;
    count_en = 1'b0;

    // game_over outranks start, which outranks pause, in every state
    unique case (state_q)
      IDLE: if (!game_over && start) begin
        state_d = RUN;
        clear   = 1'b1;
      end
      RUN: begin
        if (game_over)  state_d = OVER;
        else if (pause) state_d = PAUSED;
        else            count_en = 1'b1;
      end
      PAUSED: begin
        if (game_over)   state_d = OVER;
        else if (!pause) state_d = RUN;
      end
      OVER: if (!game_over && start) begin
        state_d = RUN;
        clear   = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (clear) begin
      presc_d = '0;
      sec_d   = '0;
      hund_d  = '0;
      tens_d  = '0;
      ones_d  = '0;
      stage_d = '0;
    end else if (count_en) begin
      if (presc_q == PRESC_TC) begin
        presc_d = '0;
        tick_d  = 1'b1;
        // Digits ripple alongside the binary count; both stop together at 255.
        if (sec_q != 8'd255) begin
          sec_d = sec_q + 8'd1;
          if (ones_q == 4'd9) begin
            ones_d = '0;
            if (tens_q == 4'd9) begin
              tens_d = '0;
              hund_d = hund_q + 4'd1;
            end else begin
              tens_d = tens_q + 4'd1;
            end
          end else begin
            ones_d = ones_q + 4'd1;
          end
          if (sec_q == 8'd9) begin
            stage_d = 2'd1;
            up_d    = 1'b1;
          end else if (sec_q == 8'd19) begin
            stage_d = 2'd2;
            up_d    = 1'b1;
          end
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    run_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      sec_q   <= '0;
      hund_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      stage_q <= '0;
      tick_q  <= 1'b0;
      up_q    <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sec_q   <= sec_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      stage_q <= stage_d;
      tick_q  <= tick_d;
      up_q    <= up_d;
      run_q   <= run_d;
    end
  end

  assign seconds  = sec_q;
  assign sec_hund = hund_q;
  assign sec_tens = tens_q;
  assign sec_ones = ones_q;
  assign stage    = stage_q;
  assign sec_tick = tick_q;
  assign stage_up = up_q;
  assign running  = run_q;

endmodule

// File: tb/tb_game_timer.sv
// Randomized and directed bench for game_timer (CLK_HZ=4) against an
// arithmetic reference model of the game clock.
module tb_game_timer;

  localparam int HZ = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_OVER = 3;

  logic       clk = 1'b0, rst_n = 1'b1;
  logic       start = 1'b0, pause = 1'b0, game_over = 1'b0;
  logic [7:0] seconds;
  logic       sec_tick, stage_up, running;
  logic [3:0] sec_hund, sec_tens, sec_ones;
  logic [1:0] stage;

  int n_checks = 0, n_errors = 0;
  int m_st, m_frac, m_sec, m_tick, m_up;
  int tick_cnt, up_cnt;

  game_timer #(.CLK_HZ(HZ)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
    .game_over(game_over), .seconds(seconds), .sec_tick(sec_tick),
    .sec_hund(sec_hund), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .stage(stage), .stage_up(stage_up), .running(running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int stage_of(input int s);
    return (s < 10) ? 0 : ((s < 20) ? 1 : 2);
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_frac = 0; m_sec = 0; m_tick = 0; m_up = 0;
  endtask

  task automatic model_step(input logic s, input logic p, input logic g);
    int old;
    m_tick = 0;
    m_up   = 0;
    case (m_st)
      S_IDLE, S_OVER: if (!g && s) begin
        m_st = S_RUN; m_frac = 0; m_sec = 0;
      end
      S_RUN: begin
        if (g)      m_st = S_OVER;
        else if (p) m_st = S_PAUSED;
        else if (m_frac == HZ - 1) begin
          m_frac = 0;
          old    = m_sec;
          if (m_sec < 255) m_sec++;
          m_tick = 1;
          m_up   = (stage_of(m_sec) != stage_of(old)) ? 1 : 0;
        end else m_frac++;
      end
      default: begin
        if (g)       m_st = S_OVER;
        else if (!p) m_st = S_RUN;
      end
    endcase
  endtask

  task automatic check_all();
    check("seconds",  seconds,  m_sec);
    check("hund",     sec_hund, m_sec / 100);
    check("tens",     sec_tens, (m_sec / 10) % 10);
    check("ones",     sec_ones, m_sec % 10);
    check("stage",    stage,    stage_of(m_sec));
    check("sec_tick", sec_tick, m_tick);
    check("stage_up", stage_up, m_up);
    check("running",  running,  (m_st == S_RUN) ? 1 : 0);
  endtask

  task automatic cycle(input logic s, input logic p, input logic g);
    @(negedge clk);
    start = s; pause = p; game_over = g;
    @(posedge clk);
    model_step(s, p, g);
    #1;
    check_all();
    tick_cnt += int'(sec_tick);
    up_cnt   += int'(stage_up);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int  n;
    logic p_lvl;

    // Reset asserted before any edge, then 100 idle cycles.
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_all();
    @(negedge clk) rst_n = 1'b1;
    tick_cnt = 0;
    repeat (100) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    check("idle_ticks", tick_cnt, 0);
    check("idle_running", running, 0);

    // Start then 40 cycles: ten seconds, one stage_up at 10.
    tick_cnt = 0; up_cnt = 0;
    cycle(1'b1, 1'b0, 1'b0);
    repeat (40) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (stage_up) check("up_at_10", seconds, 10);
    end
    check("run40_ticks", tick_cnt, 10);
    check("run40_ups", up_cnt, 1);
    check("run40_sec", seconds, 10);
    check("run40_stage", stage, 1);

    // Restart, count 2, pause 20 cycles, resume: tick after 2 more edges.
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    tick_cnt = 0;
    repeat (20) cycle(1'b0, 1'b1, 1'b0);
    check("pause_sec", seconds, 0);
    check("pause_ticks", tick_cnt, 0);
    cycle(1'b0, 1'b0, 1'b0);
    check("resume_running", running, 1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      n++;
      if (sec_tick) break;
    end
    check("resume_gap", n, 2);

    // Long run to saturation; ticks continue every 4 cycles.
    repeat (1100) cycle(1'b0, 1'b0, 1'b0);
    check("sat_sec", seconds, 255);
    check("sat_bcd", {sec_hund, sec_tens, sec_ones}, 12'h255);
    check("sat_stage", stage, 2);
    tick_cnt = 0;
    repeat (8) cycle(1'b0, 1'b0, 1'b0);
    check("sat_ticks", tick_cnt, 2);

    // Restart; pause on the terminal-count edge defers the increment.
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10 && m_frac != HZ - 1; i++) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    check("pause_tc_tick", sec_tick, 0);
    check("pause_tc_sec", seconds, 0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    check("resume_tc_tick", sec_tick, 1);
    check("resume_tc_sec", seconds, 1);

    // game_over on the terminal-count edge at seconds=7.
    for (int i = 0; i < 100 && !(m_sec == 7 && m_frac == HZ - 1); i++)
      cycle(1'b0, 1'b0, 1'b0);
    check("reach7_sec", seconds, 7);
    cycle(1'b0, 1'b0, 1'b1);
    check("go_tc_sec", seconds, 7);
    check("go_tc_tick", sec_tick, 0);
    check("go_tc_running", running, 0);
    repeat (5) cycle(1'b0, 1'b0, 1'b0);
    check("over_frozen", seconds, 7);
    cycle(1'b1, 1'b0, 1'b0);
    check("restart_sec", seconds, 0);
    check("restart_stage", stage, 0);
    check("restart_up", stage_up, 0);

    // Asynchronous reset between edges at seconds=15.
    for (int i = 0; i < 200 && m_sec != 15; i++) cycle(1'b0, 1'b0, 1'b0);
    check("reach15_sec", seconds, 15);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    check("rst_sec", seconds, 0);
    @(negedge clk) rst_n = 1'b1;
    tick_cnt = 0;
    repeat (12) cycle(1'b0, 1'b0, 1'b0);
    check("post_rst_ticks", tick_cnt, 0);

    // Random traffic, pause as a sticky level.
    p_lvl = 1'b0;
    repeat (1500) begin
      if ($urandom_range(0, 99) < 10) p_lvl = ~p_lvl;
      cycle(1'($urandom_range(0, 99) < 6), p_lvl,
            1'($urandom_range(0, 99) < 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/game_timer.md
GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 The module SHALL have parameter CLK_HZ, default 25000000, clock cycles per game second.
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port start, input, 1 bit: start or restart request, sampled each edge.
REQ-005 The module SHALL have port pause, input, 1 bit: level; high freezes timing.
REQ-006 The module SHALL have port game_over, input, 1 bit: stop request, sampled each edge.
REQ-007 The module SHALL have port seconds, output, 8 bits: elapsed game seconds, feeds the stage logic.
REQ-008 The module SHALL have port sec_tick, output, 1 bit: one-cycle pulse per seconds increment.
REQ-009 The module SHALL have port sec_hund, sec_tens and sec_ones, outputs, 4 bits each: BCD digits of seconds, for the HUD.
REQ-010 The module SHALL have port stage, output, 2 bits: 0, 1 or 2 per threshold.
REQ-011 The module SHALL have port stage_up, output, 1 bit: one-cycle pulse on stage increment.
REQ-012 The module SHALL have port running, output, 1 bit: high only in state RUN.

Function
REQ-013 The module SHALL be a 4-state FSM with states IDLE, RUN, PAUSED and OVER; all outputs SHALL be registered.
REQ-014 In IDLE, start=1 SHALL move the FSM to RUN.
REQ-015 In OVER, start=1 SHALL move the FSM to RUN.
REQ-016 On entry to RUN from IDLE or OVER, the same edge SHALL clear the prescaler, seconds, BCD digits and stage, with no stage_up.
REQ-017 In RUN, game_over=1 SHALL move the FSM to OVER.
REQ-018 In RUN, pause=1 with game_over=0 SHALL move the FSM to PAUSED.
REQ-019 In PAUSED, game_over=1 SHALL move the FSM to OVER.
REQ-020 In PAUSED, pause=0 SHALL move the FSM to RUN with no clear.
REQ-021 Priority in any state SHALL be game_over > start > pause; start in RUN or PAUSED SHALL be ignored.
REQ-022 The prescaler SHALL count 0..CLK_HZ-1 only on edges where the FSM is in RUN and no transition out of RUN occurs.
REQ-023 In PAUSED and OVER, the prescaler SHALL hold its value, so a resume continues the partial second.
REQ-024 On an edge where the prescaler equals CLK_HZ-1 and counting is enabled: prescaler SHALL wrap to 0, seconds SHALL increment, and sec_tick SHALL be 1 in the cycle seconds shows the new value.
REQ-025 The first sec_tick SHALL occur CLK_HZ edges after the start edge.
REQ-026 seconds SHALL saturate at 255; at saturation sec_tick SHALL still pulse each second while seconds holds 255.
REQ-027 The BCD digits SHALL be maintained incrementally (no divider), always equal to seconds in the same cycle, and saturate at 2/5/5.
REQ-028 stage SHALL be 0 for seconds < 10, 1 for 10..19, and 2 for >= 20, updated in the same cycle as seconds.
REQ-029 stage_up SHALL pulse exactly once at each of the increments to 10 and to 20.
REQ-030 A game_over or pause on the terminal-count edge SHALL win: no increment and no sec_tick on that edge.
REQ-031 After a pause on the terminal-count edge, the increment SHALL occur on the first counting edge after resume.
REQ-032 In OVER, seconds, BCD and stage SHALL be frozen at their final values for score display.

Reset
REQ-033 While rst_n=0, all of the following SHALL be forced immediately, independent of clk: FSM=IDLE; prescaler, seconds, sec_hund, sec_tens, sec_ones and stage = 0; sec_tick, stage_up and running = 0.
REQ-034 Reset asserted mid-RUN SHALL discard the partial second; after release, the module SHALL wait in IDLE for start.

Verification (CLK_HZ=4)
REQ-035 Bench SHALL cover reset release with no start, 100 cycles -> seconds=0, running=0, no sec_tick.
REQ-036 Bench SHALL cover start pulse then 40 cycles -> 10 sec_ticks, seconds=10, BCD 0/1/0, stage=1, exactly one stage_up coincident with seconds=10.
REQ-037 Bench SHALL cover pause high after 2 counting cycles, held 20 cycles -> seconds and prescaler unchanged; after release, next sec_tick after exactly 2 more cycles.
REQ-038 Bench SHALL cover RUN for 1100 cycles -> seconds=255, BCD 2/5/5, stage=2, sec_tick still pulsing every 4 cycles.
REQ-039 Bench SHALL cover game_over on the terminal-count edge at seconds=7 -> seconds stays 7, no sec_tick, running=0; then start -> seconds=0, stage=0, no stage_up.
REQ-040 Bench SHALL cover rst_n low between clock edges at seconds=15 -> all outputs 0 before the next edge; FSM in IDLE.
